nfc_physical_output_serializer: RTL and testbench

Transmit-side counterpart of the NAND DDR data capture path. It accepts 16-bit write data as a valid/ready stream with keep and last, packed {falling byte, rising byte}, which is the same packing the input path produces. Each accepted beat becomes one DDR DQS period of per-edge DQ/DQS values, with preamble, postamble and output-enable sequencing. Outputs feed external ODDR/OBUFT primitives, with the 90-degree DQS/DQ alignment done outside this block.

---
 rtl/nfc_physical_output_serializer.sv | 134 +++++++++++++
 tb/tb_nfc_physical_output_serializer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_physical_output_serializer.sv
// NAND DDR transmit serializer: turns a 16-bit valid/ready write stream into
// per-edge DQ/DQS values with preamble, postamble and output-enable sequencing.
module nfc_physical_output_serializer #(
  parameter int         PreambleCycles  = 2,
  parameter int         PostambleCycles = 2,
  parameter logic [7:0] PadByte         = 8'hFF
) (
  input  logic        iSystemClock,
  input  logic        iModuleResetN,
  input  logic        iPO_Start,
  input  logic        iPO_Buff_Valid,
  output logic        oPO_Buff_Ready,
  input  logic [15:0] iPO_Buff_Data,
  input  logic [1:0]  iPO_Buff_Keep,
  input  logic        iPO_Buff_Last,
  output logic [7:0]  oPO_DQ_Rising,
  output logic [7:0]  oPO_DQ_Falling,
  output logic        oPO_DQS_Rising,
  output logic        oPO_DQS_Falling,
  output logic        oPO_DQOutEnable,
  output logic        oPO_DQSOutEnable,
  output logic        oPO_Busy,
  output logic        oPO_Done,
  output logic [15:0] oPO_ByteCount
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PREAMBLE  = 2'd1,
    BURST     = 2'd2,
    POSTAMBLE = 2'd3
  } state_t;

  // The start edge itself produces the first preamble cycle, so the
  // PREAMBLE state only covers the remaining PreambleCycles-1 cycles.
  localparam logic [3:0] PreLoad    = (PreambleCycles > 1) ? 4'(PreambleCycles - 2) : 4'd0;
  localparam logic [3:0] PostLoad   = 4'(PostambleCycles);
  localparam state_t     StartState = (PreambleCycles > 1) ? PREAMBLE : BURST;

  state_t      state_r;
  logic [3:0]  phase_cnt_r;
  logic [1:0]  beat_bytes_s;
  logic [16:0] count_sum_s;
  logic [15:0] count_next_s;

  assign oPO_Buff_Ready = (state_r == BURST);

  // Saturating byte counter increment for the beat currently offered
  always_comb begin
    beat_bytes_s = {1'b0, iPO_Buff_Keep[1]} + {1'b0, iPO_Buff_Keep[0]};
    count_sum_s  = {1'b0, oPO_ByteCount} + {15'd0, beat_bytes_s};
    if (count_sum_s[16]) begin
      count_next_s = 16'hFFFF;
    end else begin
      count_next_s = count_sum_s[15:0];
    end
  end

  // Burst sequencer and all registered pad-side outputs
  always_ff @(posedge iSystemClock) begin
    if (!iModuleResetN) begin
      state_r          <= IDLE;
      phase_cnt_r      <= 4'd0;
      oPO_DQ_Rising    <= 8'h00;
      oPO_DQ_Falling   <= 8'h00;
      oPO_DQS_Rising   <= 1'b0;
      oPO_DQS_Falling  <= 1'b0;
      oPO_DQOutEnable  <= 1'b0;
      oPO_DQSOutEnable <= 1'b0;
      oPO_Busy         <= 1'b0;
      oPO_Done         <= 1'b0;
      oPO_ByteCount    <= 16'd0;
    end else begin
      oPO_Done        <= 1'b0;
      oPO_DQS_Falling <= 1'b0;
      case (state_r)
        IDLE: begin
          if (iPO_Start) begin
            state_r          <= StartState;
            phase_cnt_r      <= PreLoad;
            oPO_DQ_Rising    <= 8'h00;
            oPO_DQ_Falling   <= 8'h00;
            oPO_DQS_Rising   <= 1'b0;
            oPO_DQOutEnable  <= 1'b1;
            oPO_DQSOutEnable <= 1'b1;
            oPO_Busy         <= 1'b1;
            oPO_ByteCount    <= 16'd0;
          end else begin
            oPO_DQS_Rising <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (phase_cnt_r == 4'd0) begin
            state_r <= BURST;
          end else begin
            phase_cnt_r <= phase_cnt_r - 4'd1;
          end
        end
        BURST: begin
          oPO_DQS_Rising <= 1'b0;
          if (iPO_Buff_Valid) begin
            // A beat without its rising byte carries no data: DQS and DQ idle
            if (iPO_Buff_Keep[0]) begin
              oPO_DQS_Rising <= 1'b1;
              oPO_DQ_Rising  <= iPO_Buff_Data[7:0];
              oPO_DQ_Falling <= iPO_Buff_Keep[1] ? iPO_Buff_Data[15:8] : PadByte;
            end
            oPO_ByteCount <= count_next_s;
            if (iPO_Buff_Last) begin
              state_r     <= POSTAMBLE;
              phase_cnt_r <= PostLoad;
            end
          end
        end
        POSTAMBLE: begin
          oPO_DQS_Rising <= 1'b0;
          if (phase_cnt_r == 4'd0) begin
            state_r          <= IDLE;
            oPO_DQOutEnable  <= 1'b0;
            oPO_DQSOutEnable <= 1'b0;
            oPO_Busy         <= 1'b0;
          end else begin
            phase_cnt_r <= phase_cnt_r - 4'd1;
            oPO_Done    <= (phase_cnt_r == 4'd1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nfc_physical_output_serializer.sv
// Self-checking bench: per-cycle stimulus tables run through a timeline model
// of the serializer, plus directed anchors taken straight from the burst timing.
module tb_nfc_physical_output_serializer;

  localparam int MAXC = 80;
  localparam logic [7:0] PAD = 8'hFF;
  // Bit positions inside the packed observation vector
  localparam int F_RDY = 38, F_BUSY = 37, F_DONE = 36, F_DQOE = 35, F_DQSOE = 34, F_DQS = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, valid, last;
  logic [15:0] data;
  logic [1:0] keep;

  logic r1, dqsr1, dqsf1, dqoe1, dqsoe1, busy1, done1;
  logic [7:0] dqr1, dqf1;
  logic [15:0] cnt1;
  logic r2, dqsr2, dqsf2, dqoe2, dqsoe2, busy2, done2;
  logic [7:0] dqr2, dqf2;
  logic [15:0] cnt2;

  logic sel;
  logic [38:0] obs_vec;

  int checks = 0;
  int errors = 0;

  logic rn_a[MAXC], st_a[MAXC], vl_a[MAXC], ls_a[MAXC];
  logic [15:0] dt_a[MAXC];
  logic [1:0] kp_a[MAXC];
  logic [38:0] ex[MAXC];
  logic [38:0] ob[MAXC];

  nfc_physical_output_serializer dut1 (
    .iSystemClock(clk), .iModuleResetN(rst_n), .iPO_Start(start),
    .iPO_Buff_Valid(valid), .oPO_Buff_Ready(r1), .iPO_Buff_Data(data),
    .iPO_Buff_Keep(keep), .iPO_Buff_Last(last),
    .oPO_DQ_Rising(dqr1), .oPO_DQ_Falling(dqf1), .oPO_DQS_Rising(dqsr1),
    .oPO_DQS_Falling(dqsf1), .oPO_DQOutEnable(dqoe1), .oPO_DQSOutEnable(dqsoe1),
    .oPO_Busy(busy1), .oPO_Done(done1), .oPO_ByteCount(cnt1)
  );

  nfc_physical_output_serializer #(.PreambleCycles(1), .PostambleCycles(3), .PadByte(8'hFF)) dut2 (
    .iSystemClock(clk), .iModuleResetN(rst_n), .iPO_Start(start),
    .iPO_Buff_Valid(valid), .oPO_Buff_Ready(r2), .iPO_Buff_Data(data),
    .iPO_Buff_Keep(keep), .iPO_Buff_Last(last),
    .oPO_DQ_Rising(dqr2), .oPO_DQ_Falling(dqf2), .oPO_DQS_Rising(dqsr2),
    .oPO_DQS_Falling(dqsf2), .oPO_DQOutEnable(dqoe2), .oPO_DQSOutEnable(dqsoe2),
    .oPO_Busy(busy2), .oPO_Done(done2), .oPO_ByteCount(cnt2)
  );

  always_comb begin
    if (sel) obs_vec = {r2, busy2, done2, dqoe2, dqsoe2, dqsr2, dqsf2, dqr2, dqf2, cnt2};
    else     obs_vec = {r1, busy1, done1, dqoe1, dqsoe1, dqsr1, dqsf1, dqr1, dqf1, cnt1};
  end

  function automatic logic [15:0] sat_add(input logic [15:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic put(input int t, input bit rdy, input bit bsy, input bit dn, input bit oe,
                     input bit dqs, input logic [7:0] dr, input logic [7:0] df, input logic [15:0] bc);
    if (t < MAXC) ex[t] = {rdy, bsy, dn, oe, oe, dqs, 1'b0, dr, df, bc};
  endtask

  // Timeline model: each burst is laid out as preamble, accept window,
  // postamble and idle; a reset edge inside the burst truncates it.
  task automatic model(input int pre, input int post, input int n);
    int e, j, lst, endc, x;
    logic [7:0] dr, df;
    logic [15:0] bc;
    bit dqs;
    dr = 8'h00; df = 8'h00; bc = 16'd0; e = 0;
    while (e < n) begin
      if (!rn_a[e]) begin
        dr = 8'h00; df = 8'h00; bc = 16'd0;
        put(e + 1, 0, 0, 0, 0, 0, dr, df, bc);
        e++;
      end else if (!st_a[e]) begin
        put(e + 1, 0, 0, 0, 0, 0, dr, df, bc);
        e++;
      end else begin
        bc = 16'd0; dr = 8'h00; df = 8'h00;
        for (int t = e + 1; t <= e + pre; t++) put(t, t == e + pre, 1, 0, 1, 0, dr, df, bc);
        lst = n;
        j = e + pre;
        while (j < n && lst == n) begin
          dqs = 0;
          if (vl_a[j]) begin
            if (kp_a[j][0]) begin
              dqs = 1;
              dr = dt_a[j][7:0];
              df = kp_a[j][1] ? dt_a[j][15:8] : PAD;
            end
            bc = sat_add(bc, int'(kp_a[j][0]) + int'(kp_a[j][1]));
            if (ls_a[j]) lst = j;
          end
          put(j + 1, lst == n, 1, 0, 1, dqs, dr, df, bc);
          j++;
        end
        endc = lst + 1 + post;
        for (int t = lst + 2; t <= endc; t++) put(t, 0, 1, t == endc, 1, 0, dr, df, bc);
        put(endc + 1, 0, 0, 0, 0, 0, dr, df, bc);
        x = n;
        for (int t = e + 1; t <= endc && t < n; t++) if (!rn_a[t] && x == n) x = t;
        e = (x < n) ? x : endc + 1;
      end
    end
  endtask

  task automatic clear_stim;
    for (int c = 0; c < MAXC; c++) begin
      rn_a[c] = 1'b1; st_a[c] = 1'b0; vl_a[c] = 1'b0;
      dt_a[c] = 16'($urandom); kp_a[c] = 2'($urandom_range(0, 3)); ls_a[c] = 1'($urandom_range(0, 1));
    end
    rn_a[0] = 1'b0;
  endtask

  task automatic beat(input int c, input logic [15:0] d, input logic [1:0] k, input logic l);
    vl_a[c] = 1'b1; dt_a[c] = d; kp_a[c] = k; ls_a[c] = l;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      rst_n = rn_a[c]; start = st_a[c]; valid = vl_a[c];
      data = dt_a[c]; keep = kp_a[c]; last = ls_a[c];
      @(negedge clk);
      ob[c] = obs_vec;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0;
  endtask

  task automatic test_reset;
    int n = 5;
    sel = 1'b0;
    clear_stim();
    for (int c = 0; c < 4; c++) begin rn_a[c] = 1'b0; st_a[c] = 1'b1; vl_a[c] = 1'b1; end
    model(2, 2, n);
    run(n);
    for (int c = 1; c < n; c++) begin
      checks++;
      if (ob[c] !== ex[c]) begin errors++; $display("FAIL reset_trace cycle %0d: got %h expected %h", c, ob[c], ex[c]); end
      checks++;
      if (ob[c] !== 39'd0) begin errors++; $display("FAIL reset_zero cycle %0d: got %h expected 0", c, ob[c]); end
    end
  endtask

  task automatic test_basic_burst;
    int n = 12;
    sel = 1'b0;
    clear_stim();
    st_a[1] = 1'b1; vl_a[1] = 1'b1; vl_a[2] = 1'b1;
    beat(3, 16'hA55A, 2'b11, 1'b0);
    beat(4, 16'h3C01, 2'b11, 1'b0);
    beat(5, 16'h7788, 2'b11, 1'b1);
    model(2, 2, n);
    run(n);
    for (int c = 1; c < n; c++) begin
      checks++;
      if (ob[c] !== ex[c]) begin errors++; $display("FAIL basic_trace cycle %0d: got %h expected %h", c, ob[c], ex[c]); end
    end
    checks++;
    if ({ob[2][F_DQSOE], ob[2][F_DQS], ob[3][F_DQSOE], ob[3][F_DQS]} !== 4'b1010) begin
      errors++; $display("FAIL basic_preamble: got %b expected 1010", {ob[2][F_DQSOE], ob[2][F_DQS], ob[3][F_DQSOE], ob[3][F_DQS]});
    end
    checks++;
    if ({ob[2][F_RDY], ob[3][F_RDY], ob[4][F_RDY], ob[5][F_RDY], ob[6][F_RDY]} !== 5'b01110) begin
      errors++; $display("FAIL basic_ready: got %b expected 01110", {ob[2][F_RDY], ob[3][F_RDY], ob[4][F_RDY], ob[5][F_RDY], ob[6][F_RDY]});
    end
    checks++;
    if ({ob[4][31:16], ob[5][31:16], ob[6][31:16]} !== 48'h5AA5_013C_8877) begin
      errors++; $display("FAIL basic_data: got %h expected 5aa5013c8877", {ob[4][31:16], ob[5][31:16], ob[6][31:16]});
    end
    checks++;
    if ({ob[7][F_DONE], ob[8][F_DONE], ob[8][F_DQSOE], ob[9][F_DQSOE], ob[9][F_BUSY]} !== 5'b01100) begin
      errors++; $display("FAIL basic_done_oe: got %b expected 01100", {ob[7][F_DONE], ob[8][F_DONE], ob[8][F_DQSOE], ob[9][F_DQSOE], ob[9][F_BUSY]});
    end
    checks++;
    if (ob[9][15:0] !== 16'd6) begin errors++; $display("FAIL basic_count: got %0d expected 6", ob[9][15:0]); end
  endtask

  task automatic test_stall;
    int n = 14;
    sel = 1'b0;
    clear_stim();
    st_a[1] = 1'b1;
    beat(3, 16'hA55A, 2'b11, 1'b0);
    beat(7, 16'h3C01, 2'b11, 1'b0);
    beat(8, 16'h7788, 2'b11, 1'b1);
    model(2, 2, n);
    run(n);
    for (int c = 1; c < n; c++) begin
      checks++;
      if (ob[c] !== ex[c]) begin errors++; $display("FAIL stall_trace cycle %0d: got %h expected %h", c, ob[c], ex[c]); end
    end
    checks++;
    if ({ob[5][F_DQS], ob[5][F_DQOE], ob[6][F_DQS], ob[6][F_DQOE], ob[7][F_DQS], ob[7][F_DQOE]} !== 6'b010101) begin
      errors++; $display("FAIL stall_dqs_oe: got %b expected 010101", {ob[5][F_DQS], ob[5][F_DQOE], ob[6][F_DQS], ob[6][F_DQOE], ob[7][F_DQS], ob[7][F_DQOE]});
    end
    checks++;
    if ({ob[5][31:16], ob[6][31:16], ob[7][31:16]} !== 48'h5AA5_5AA5_5AA5) begin
      errors++; $display("FAIL stall_dq_hold: got %h expected 5aa55aa55aa5", {ob[5][31:16], ob[6][31:16], ob[7][31:16]});
    end
    checks++;
    if (ob[12][15:0] !== 16'd6) begin errors++; $display("FAIL stall_count: got %0d expected 6", ob[12][15:0]); end
  endtask

  task automatic test_pad_byte;
    int n = 10;
    sel = 1'b0;
    clear_stim();
    st_a[1] = 1'b1;
    beat(3, 16'h1234, 2'b01, 1'b1);
    model(2, 2, n);
    run(n);
    for (int c = 1; c < n; c++) begin
      checks++;
      if (ob[c] !== ex[c]) begin errors++; $display("FAIL pad_trace cycle %0d: got %h expected %h", c, ob[c], ex[c]); end
    end
    checks++;
    if ({ob[4][F_DQS], ob[4][31:16]} !== {1'b1, 16'h34FF}) begin
      errors++; $display("FAIL pad_data: got %h expected 134ff", {ob[4][F_DQS], ob[4][31:16]});
    end
    checks++;
    if ({ob[6][F_DONE], ob[7][15:0]} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL pad_count: got %h expected 10001", {ob[6][F_DONE], ob[7][15:0]});
    end
  endtask

  task automatic test_reset_mid_burst;
    int n = 20;
    logic any_done;
    sel = 1'b0;
    clear_stim();
    st_a[1] = 1'b1;
    beat(3, 16'($urandom), 2'b11, 1'b0);
    beat(4, 16'($urandom), 2'b11, 1'b0);
    beat(5, 16'($urandom), 2'b11, 1'b0);
    rn_a[4] = 1'b0;
    st_a[7] = 1'b1;
    beat(9, 16'($urandom), 2'b11, 1'b0);
    beat(10, 16'($urandom), 2'b11, 1'b1);
    model(2, 2, n);
    run(n);
    for (int c = 1; c < n; c++) begin
      checks++;
      if (ob[c] !== ex[c]) begin errors++; $display("FAIL midrst_trace cycle %0d: got %h expected %h", c, ob[c], ex[c]); end
    end
    checks++;
    if ({ob[5][F_RDY], ob[5][F_BUSY], ob[5][F_DQOE], ob[5][F_DQSOE]} !== 4'b0000) begin
      errors++; $display("FAIL midrst_idle: got %b expected 0000", {ob[5][F_RDY], ob[5][F_BUSY], ob[5][F_DQOE], ob[5][F_DQSOE]});
    end
    any_done = 1'b0;
    for (int c = 5; c < 13; c++) any_done = any_done | ob[c][F_DONE];
    checks++;
    if (any_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b expected 0", any_done); end
    checks++;
    if ({ob[13][F_DONE], ob[14][15:0]} !== {1'b1, 16'd4}) begin
      errors++; $display("FAIL midrst_restart: got %h expected 10004", {ob[13][F_DONE], ob[14][15:0]});
    end
  endtask

  task automatic test_start_ignored;
    int n = 16;
    sel = 1'b0;
    clear_stim();
    st_a[1] = 1'b1;
    beat(3, 16'($urandom), 2'b11, 1'b0);
    beat(4, 16'($urandom), 2'b11, 1'b1);
    st_a[4] = 1'b1; st_a[6] = 1'b1; st_a[8] = 1'b1;
    beat(10, 16'($urandom), 2'b01, 1'b1);
    model(2, 2, n);
    run(n);
    for (int c = 1; c < n; c++) begin
      checks++;
      if (ob[c] !== ex[c]) begin errors++; $display("FAIL start_trace cycle %0d: got %h expected %h", c, ob[c], ex[c]); end
    end
    checks++;
    if ({ob[7][F_DONE], ob[8][F_DQSOE], ob[8][15:0]} !== {1'b1, 1'b0, 16'd4}) begin
      errors++; $display("FAIL start_ignored: got %h expected 20004", {ob[7][F_DONE], ob[8][F_DQSOE], ob[8][15:0]});
    end
    checks++;
    if ({ob[9][F_DQSOE], ob[9][F_BUSY], ob[9][15:0]} !== {1'b1, 1'b1, 16'd0}) begin
      errors++; $display("FAIL start_restart: got %h expected 30000", {ob[9][F_DQSOE], ob[9][F_BUSY], ob[9][15:0]});
    end
    checks++;
    if (ob[14][15:0] !== 16'd1) begin errors++; $display("FAIL start_count: got %0d expected 1", ob[14][15:0]); end
  endtask

  task automatic test_short_preamble;
    int n = 12;
    sel = 1'b1;
    clear_stim();
    st_a[1] = 1'b1;
    beat(2, 16'($urandom), 2'b11, 1'b0);
    beat(3, 16'($urandom), 2'b11, 1'b1);
    model(1, 3, n);
    run(n);
    for (int c = 1; c < n; c++) begin
      checks++;
      if (ob[c] !== ex[c]) begin errors++; $display("FAIL short_trace cycle %0d: got %h expected %h", c, ob[c], ex[c]); end
    end
    checks++;
    if ({ob[1][F_DQSOE], ob[2][F_DQSOE], ob[2][F_DQS], ob[2][F_RDY], ob[3][F_DQS]} !== 5'b01011) begin
      errors++; $display("FAIL short_preamble: got %b expected 01011", {ob[1][F_DQSOE], ob[2][F_DQSOE], ob[2][F_DQS], ob[2][F_RDY], ob[3][F_DQS]});
    end
    checks++;
    if ({ob[5][F_DQS], ob[6][F_DQS], ob[7][F_DQS], ob[5][F_DQSOE], ob[6][F_DQSOE], ob[7][F_DQSOE], ob[8][F_DQSOE]} !== 7'b0001110) begin
      errors++; $display("FAIL short_postamble: got %b expected 0001110", {ob[5][F_DQS], ob[6][F_DQS], ob[7][F_DQS], ob[5][F_DQSOE], ob[6][F_DQSOE], ob[7][F_DQSOE], ob[8][F_DQSOE]});
    end
    checks++;
    if ({ob[5][F_DONE], ob[6][F_DONE], ob[7][F_DONE]} !== 3'b001) begin
      errors++; $display("FAIL short_done: got %b expected 001", {ob[5][F_DONE], ob[6][F_DONE], ob[7][F_DONE]});
    end
  endtask

  task automatic test_random_bursts;
    logic [1:0] kopt [4];
    kopt[0] = 2'b11; kopt[1] = 2'b11; kopt[2] = 2'b01; kopt[3] = 2'b00;
    for (int it = 0; it < 8; it++) begin
      sel = 1'(it % 2);
      clear_stim();
      for (int c = 1; c < MAXC; c++) begin
        rn_a[c] = ($urandom_range(0, 59) != 0);
        st_a[c] = ($urandom_range(0, 5) == 0);
        vl_a[c] = ($urandom_range(0, 9) < 7);
        dt_a[c] = 16'($urandom);
        kp_a[c] = kopt[$urandom_range(0, 3)];
        ls_a[c] = ($urandom_range(0, 5) == 0);
      end
      model(sel ? 1 : 2, sel ? 3 : 2, MAXC);
      run(MAXC);
      for (int c = 1; c < MAXC; c++) begin
        checks++;
        if (ob[c] !== ex[c]) begin errors++; $display("FAIL random%0d cycle %0d: got %h expected %h", it, c, ob[c], ex[c]); end
      end
    end
  endtask

  task automatic test_saturation;
    int acc, cyc;
    bit mid_done, seen;
    sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b1; keep = 2'b11; last = 1'b0;
    acc = 0; cyc = 0; mid_done = 1'b0;
    while (acc < 32768 && cyc < 40000) begin
      @(negedge clk);
      data = 16'($urandom);
      last = (acc == 32767);
      if (acc == 32767 && !mid_done) begin
        mid_done = 1'b1;
        checks++;
        if (obs_vec[15:0] !== 16'hFFFE) begin errors++; $display("FAIL sat_near: got %h expected fffe", obs_vec[15:0]); end
      end
      if (obs_vec[F_RDY]) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    valid = 1'b0; last = 1'b0;
    checks++;
    if (acc != 32768) begin errors++; $display("FAIL sat_accept: got %0d beats expected 32768", acc); end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = obs_vec[F_DONE];
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL sat_done: got no done within 10 cycles expected done"); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({obs_vec[F_BUSY], obs_vec[15:0]} !== {1'b0, 16'hFFFF}) begin
      errors++; $display("FAIL sat_count: got %h expected 0ffff", {obs_vec[F_BUSY], obs_vec[15:0]});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
    data = 16'h0000; keep = 2'b00; sel = 1'b0;
    test_reset();
    test_basic_burst();
    test_stall();
    test_pad_byte();
    test_reset_mid_burst();
    test_start_ignored();
    test_short_preamble();
    test_random_bursts();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
